brick_field_scanner: RTL and testbench

Next-generation brick field controller for the breakout game. Bricks now carry multi-hit health instead of a single alive bit. Collision is checked by a sequential scan, one brick per cycle, started once per frame. The block reports at most one hit per frame over a valid/ready handshake, keeps a running score and a bricks-left count, and supports runtime level reloads. It sits between the ball motion logic (which consumes hit reports to bounce the ball) and the video/score renderers.

---
 rtl/brick_field_scanner_if.sv | 27 ++
 rtl/brick_field_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_brick_field_scanner.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_field_scanner_if.sv
// Hit-report channel from the brick field scanner to the ball motion logic.
// One report is outstanding at a time; the payload holds until hit_ready is seen.
interface brick_field_scanner_if #(
    parameter int unsigned IDX_W = 6
) ();
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_side;
    logic             hit_destroyed;

    modport master (
        output hit_valid,
        output hit_idx,
        output hit_side,
        output hit_destroyed,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_idx,
        input  hit_side,
        input  hit_destroyed,
        output hit_ready
    );
endinterface

// File: rtl/brick_field_scanner.sv
// Multi-hit brick field: per-frame sequential collision scan (one brick per cycle),
// single hit report per frame, running score, bricks-left count and level reload.
module brick_field_scanner #(
    parameter int BRICK_ROWS   = 5,
    parameter int BRICK_COLS   = 10,
    parameter int BRICK_WIDTH  = 64,
    parameter int BRICK_HEIGHT = 16,
    parameter int FIELD_X0     = 0,
    parameter int FIELD_Y0     = 0,
    parameter int BALL_SIZE    = 6,
    parameter int HP_W         = 2,
    parameter int SCORE_W      = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         frame_tick,
    input  logic [9:0]                                   ball_x,
    input  logic [9:0]                                   ball_y,
    input  logic signed [2:0]                            ball_vx,
    input  logic signed [2:0]                            ball_vy,
    input  logic                                         level_load,
    input  logic [BRICK_ROWS*HP_W-1:0]                   level_hp,
    output logic [BRICK_ROWS*BRICK_COLS-1:0]             brick_alive,
    output logic                                         busy,
    brick_field_scanner_if.master                        hit,
    output logic [SCORE_W-1:0]                           score,
    output logic [$clog2(BRICK_ROWS*BRICK_COLS+1)-1:0]   bricks_left,
    output logic                                         field_clear
);

    localparam int unsigned N     = BRICK_ROWS * BRICK_COLS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned ROW_W = (BRICK_ROWS > 1) ? $clog2(BRICK_ROWS) : 1;
    localparam int unsigned COL_W = (BRICK_COLS > 1) ? $clog2(BRICK_COLS) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StScan, StReport} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic signed [11:0]        nx_q, nx_d, ny_q, ny_d;
    logic [HP_W-1:0]           hp_q [N];
    logic [HP_W-1:0]           hp_d [N];
    logic [BRICK_ROWS*HP_W-1:0] lvl_q, lvl_d;
    logic [CNT_W-1:0]          left_q, left_d, load_cnt_q, load_cnt_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic                      clear_q;
    logic [IDX_W-1:0]          hit_idx_q, hit_idx_d;
    logic                      hit_side_q, hit_side_d;
    logic                      hit_des_q, hit_des_d;

    // Geometry of the brick under examination, 32-bit signed throughout.
    logic signed [31:0] bx, by, nx, ny, dx, dy, adx, ady;
    logic               overlap, side;
    logic [HP_W-1:0]    hp_cur, row_hp;
    logic [SCORE_W:0]   score_sum;
    logic               last_idx;

    always_comb begin
        nx      = {{20{nx_q[11]}}, nx_q};
        ny      = {{20{ny_q[11]}}, ny_q};
        bx      = FIELD_X0 + int'(col_q) * BRICK_WIDTH;
        by      = FIELD_Y0 + int'(row_q) * BRICK_HEIGHT;
        overlap = (nx < bx + BRICK_WIDTH) && (nx + BALL_SIZE > bx) &&
                  (ny < by + BRICK_HEIGHT) && (ny + BALL_SIZE > by);
        dx      = (nx + BALL_SIZE / 2) - (bx + BRICK_WIDTH / 2);
        dy      = (ny + BALL_SIZE / 2) - (by + BRICK_HEIGHT / 2);
        adx     = (dx < 0) ? -dx : dx;
        ady     = (dy < 0) ? -dy : dy;
        // Ties resolve to a top/bottom bounce.
        side    = (adx * BRICK_HEIGHT) > (ady * BRICK_WIDTH);
    end

    always_comb begin
        hp_cur    = hp_q[idx_q];
        row_hp    = lvl_q[int'(row_q) * HP_W +: HP_W];
        last_idx  = (idx_q == IDX_W'(N - 1));
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(BRICK_ROWS - int'(row_q));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        hp_d       = hp_q;
        lvl_d      = lvl_q;
        left_d     = left_q;
        load_cnt_d = load_cnt_q;
        score_d    = score_q;
        hit_idx_d  = hit_idx_q;
        hit_side_d = hit_side_q;
        hit_des_d  = hit_des_q;

        unique case (state_q)
            StIdle: begin
                if (level_load) begin
                    state_d    = StLoad;
                    idx_d      = '0;
                    row_d      = '0;
                    col_d      = '0;
                    lvl_d      = level_hp;
                    load_cnt_d = '0;
                end else if (frame_tick) begin
                    state_d = StScan;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    nx_d    = $signed({2'b00, ball_x}) + 12'(ball_vx);
                    ny_d    = $signed({2'b00, ball_y}) + 12'(ball_vy);
                end
            end

            StLoad: begin
                hp_d[idx_q] = row_hp;
                load_cnt_d  = load_cnt_q + {{(CNT_W - 1){1'b0}}, (row_hp != '0)};
                if (last_idx) begin
                    left_d  = load_cnt_d;
                    state_d = StIdle;
                end
            end

            StScan: begin
                if ((hp_cur != '0) && overlap) begin
                    hp_d[idx_q] = hp_cur - HP_W'(1);
                    hit_idx_d   = idx_q;
                    hit_side_d  = side;
                    hit_des_d   = (hp_cur == HP_W'(1));
                    if (hp_cur == HP_W'(1)) begin
                        left_d  = left_q - CNT_W'(1);
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    end
                    state_d = StReport;
                end else if (last_idx) begin
                    state_d = StIdle;
                end
            end

            StReport: begin
                if (hit.hit_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        // Shared row/col walk for both LOAD and SCAN; harmless when leaving the state.
        if ((state_q == StLoad || state_q == StScan) && state_d == state_q && !last_idx) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_q == COL_W'(BRICK_COLS - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            for (int i = 0; i < int'(N); i++) begin
                hp_q[i] <= HP_W'(1);
            end
            lvl_q      <= '0;
            left_q     <= CNT_W'(N);
            load_cnt_q <= '0;
            score_q    <= '0;
            clear_q    <= 1'b0;
            hit_idx_q  <= '0;
            hit_side_q <= 1'b0;
            hit_des_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            hp_q       <= hp_d;
            lvl_q      <= lvl_d;
            left_q     <= left_d;
            load_cnt_q <= load_cnt_d;
            score_q    <= score_d;
            clear_q    <= (left_q == '0);
            hit_idx_q  <= hit_idx_d;
            hit_side_q <= hit_side_d;
            hit_des_q  <= hit_des_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            brick_alive[i] = (hp_q[i] != '0);
        end
    end

    assign busy              = (state_q != StIdle);
    assign hit.hit_valid     = (state_q == StReport);
    assign hit.hit_idx       = hit_idx_q;
    assign hit.hit_side      = hit_side_q;
    assign hit.hit_destroyed = hit_des_q;
    assign score             = score_q;
    assign bricks_left       = left_q;
    assign field_clear       = clear_q;

endmodule

// File: tb/tb_brick_field_scanner.sv
// Scoreboard bench for brick_field_scanner: a geometric reference model predicts each
// frame's hit; a negedge monitor checks reports, latency and hold-while-stalled.
module tb_brick_field_scanner;

    localparam int ROWS = 5;
    localparam int COLS = 10;
    localparam int N    = 50;
    localparam int BW   = 64;
    localparam int BH   = 16;
    localparam int BS   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic [9:0]        ball_x = '0;
    logic [9:0]        ball_y = '0;
    logic signed [2:0] ball_vx = '0;
    logic signed [2:0] ball_vy = '0;
    logic              level_load = 1'b0;
    logic [9:0]        level_hp = '0;
    logic [N-1:0]      brick_alive;
    logic              busy;
    logic [15:0]       score;
    logic [5:0]        bricks_left;
    logic              field_clear;

    brick_field_scanner_if #(.IDX_W(6)) hif ();

    brick_field_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_vx     (ball_vx),
        .ball_vy     (ball_vy),
        .level_load  (level_load),
        .level_hp    (level_hp),
        .brick_alive (brick_alive),
        .busy        (busy),
        .hit         (hif),
        .score       (score),
        .bricks_left (bricks_left),
        .field_clear (field_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int side;
        int destroyed;
        int score;
        int left;
        int rise;
    } exp_t;

    exp_t q[$];
    int   m_hp[N];
    int   m_score, m_left;
    int   checks = 0, failures = 0, cyc = 0, reports = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 hif.hit_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_hp[i] = 1;
        m_score = 0;
        m_left  = N;
    endfunction

    function automatic logic [N-1:0] model_alive();
        logic [N-1:0] a;
        for (int i = 0; i < N; i++) a[i] = (m_hp[i] != 0);
        return a;
    endfunction

    // First live brick the ball's next position overlaps, with bounce face and scoring.
    function automatic void model_frame(int x, int y, int vx, int vy,
                                        output int k, output exp_t e);
        int nx, ny, r, c, bx, by, dx, dy;
        nx = x + vx;
        ny = y + vy;
        k  = -1;
        e  = '{default: 0};
        for (int i = 0; i < N; i++) begin
            bx = (i % COLS) * BW;
            by = (i / COLS) * BH;
            if (m_hp[i] > 0 && nx < bx + BW && nx + BS > bx && ny < by + BH && ny + BS > by) begin
                k = i;
                break;
            end
        end
        if (k >= 0) begin
            r  = k / COLS;
            c  = k % COLS;
            dx = (nx + BS / 2) - (c * BW + BW / 2);
            dy = (ny + BS / 2) - (r * BH + BH / 2);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            m_hp[k]--;
            if (m_hp[k] == 0) begin
                m_score = (m_score + ROWS - r > 65535) ? 65535 : m_score + ROWS - r;
                m_left--;
            end
            e.idx       = k;
            e.side      = (dx * BH > dy * BW) ? 1 : 0;
            e.destroyed = (m_hp[k] == 0) ? 1 : 0;
            e.score     = m_score;
            e.left      = m_left;
        end
    endfunction

    // Monitor: checks every report against the scoreboard head.
    bit prev_valid = 1'b0, prev_acc = 1'b0;
    int h_idx, h_side, h_des;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_acc) chk("valid_falls_after_accept", hif.hit_valid, 0);
            if (hif.hit_valid && !prev_acc) begin
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_report: idx %0d, none expected", hif.hit_idx);
                    end else begin
                        chk("hit_idx", hif.hit_idx, q[0].idx);
                        chk("hit_side", hif.hit_side, q[0].side);
                        chk("hit_destroyed", hif.hit_destroyed, q[0].destroyed);
                        chk("hit_latency_cycle", cyc, q[0].rise);
                        chk("score_at_report", score, q[0].score);
                        chk("left_at_report", bricks_left, q[0].left);
                    end
                end else begin
                    chk("hold_idx", hif.hit_idx, h_idx);
                    chk("hold_side", hif.hit_side, h_side);
                    chk("hold_destroyed", hif.hit_destroyed, h_des);
                end
                h_idx  = hif.hit_idx;
                h_side = hif.hit_side;
                h_des  = hif.hit_destroyed;
                if (hif.hit_ready) begin
                    reports++;
                    if (q.size() > 0) void'(q.pop_front());
                    prev_acc = 1'b1;
                end else begin
                    prev_acc = 1'b0;
                end
            end else begin
                prev_acc = 1'b0;
            end
            prev_valid = hif.hit_valid;
        end
    end

    task automatic check_state(string name);
        chk({name, "_score"}, score, m_score);
        chk({name, "_bricks_left"}, bricks_left, m_left);
        chk({name, "_brick_alive"}, brick_alive, model_alive());
        chk({name, "_field_clear"}, field_clear, (m_left == 0) ? 1 : 0);
    endtask

    task automatic wait_idle(output int bcnt);
        int n;
        bcnt = 0;
        n    = 0;
        while (busy && n < 400) begin
            bcnt++;
            n++;
            @(posedge clk);
            #1;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic do_frame(int x, int y, int vx, int vy, bit stall);
        int   k, c, bcnt, rep0, n;
        exp_t e;
        model_frame(x, y, vx, vy, k, e);
        rep0 = reports;
        @(posedge clk);
        #1;
        ball_x     = 10'(x);
        ball_y     = 10'(y);
        ball_vx    = 3'(vx);
        ball_vy    = 3'(vy);
        frame_tick = 1'b1;
        c          = cyc;
        if (k >= 0) begin
            e.rise = c + 2 + k;
            q.push_back(e);
        end
        if (stall) hif.hit_ready = 1'b0;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        if (stall) begin
            n = 0;
            while (!hif.hit_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("stall_reached_report", hif.hit_valid, 1);
            repeat (2) @(posedge clk);
            #1 frame_tick = 1'b1;
            @(posedge clk);
            #1 frame_tick = 1'b0;
            repeat (2) @(posedge clk);
            #1 hif.hit_ready = 1'b1;
        end
        wait_idle(bcnt);
        if (k < 0) begin
            chk("nohit_busy_cycles", bcnt, N);
            chk("nohit_no_report", reports, rep0);
        end else begin
            chk("hit_single_report", reports, rep0 + 1);
        end
        @(posedge clk);
        #1 check_state("frame");
    endtask

    task automatic do_load(logic [9:0] rows, bit with_tick);
        int bcnt, rep0;
        for (int i = 0; i < N; i++) m_hp[i] = int'(rows[(i / COLS) * 2 +: 2]);
        m_left = 0;
        for (int i = 0; i < N; i++) if (m_hp[i] != 0) m_left++;
        rep0 = reports;
        @(posedge clk);
        #1;
        level_hp   = rows;
        level_load = 1'b1;
        frame_tick = with_tick;
        ball_x     = 10'd30;
        ball_y     = 10'd20;
        ball_vx    = 3'sd0;
        ball_vy    = -3'sd2;
        @(posedge clk);
        #1;
        level_load = 1'b0;
        frame_tick = 1'b0;
        wait_idle(bcnt);
        chk("load_busy_cycles", bcnt, N);
        chk("load_no_report", reports, rep0);
        @(posedge clk);
        #1 check_state("load");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        model_reset();
    endtask

    initial begin
        int   k, n;
        exp_t e;
        hif.hit_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_hit_valid", hif.hit_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_hit_idx", hif.hit_idx, 0);
        chk("reset_hit_side", hif.hit_side, 0);
        chk("reset_hit_destroyed", hif.hit_destroyed, 0);

        do_frame(30, 20, 0, -2, 1'b0);
        chk("first_hit_alive10", brick_alive[10], 0);
        do_frame(60, 4, 2, 0, 1'b0);
        chk("double_overlap_brick1_alive", brick_alive[1], 1);

        do_load(10'b11_11_11_11_11, 1'b0);
        repeat (3) do_frame(30, 20, 0, -2, 1'b0);
        do_frame(100, 20, 0, -2, 1'b1);

        rand_ready = 1'b1;
        for (int round = 0; round < 2; round++) begin
            do_load(10'($urandom), 1'b0);
            for (int f = 0; f < 25; f++) begin
                do_frame($urandom_range(0, 660), $urandom_range(0, 95),
                         int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, 1'b0);
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 hif.hit_ready = 1'b1;

        // Reset while a report is pending discards it.
        do_reset();
        model_frame(30, 20, 0, -2, k, e);
        e.rise = -1;
        @(posedge clk);
        #1;
        hif.hit_ready = 1'b0;
        ball_x = 10'd30; ball_y = 10'd20; ball_vx = 3'sd0; ball_vy = -3'sd2;
        frame_tick = 1'b1;
        e.rise = cyc + 2 + k;
        q.push_back(e);
        @(posedge clk);
        #1 frame_tick = 1'b0;
        n = 0;
        while (!hif.hit_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_report", hif.hit_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        model_reset();
        chk("midrst_hit_valid", hif.hit_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_score", score, 0);
        chk("midrst_left", bricks_left, N);
        chk("midrst_alive", brick_alive, model_alive());
        rst = 1'b0;
        hif.hit_ready = 1'b1;

        do_reset();
        do_load(10'b01_01_01_01_01, 1'b1);
        do_load(10'b00_00_00_00_01, 1'b0);
        for (int c = 0; c < COLS; c++) do_frame(c * BW + 30, 4, 0, 0, 1'b0);
        chk("final_field_clear", field_clear, 1);
        chk("final_score", score, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
